key_event_gen: RTL and testbench

KEY_EVENT_GEN -- requirements
Module: key_event_gen

---
 rtl/key_event_gen.sv | 146 ++++++++++++++
 tb/tb_key_event_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/key_event_gen.sv
// Key event generator: synchronizes a debounced key and emits press, release and long-press pulses.
// Optional auto-repeat in the LONG state is built when KEY_EVENT_REPEAT_EN is defined.
module key_event_gen #(
   parameter logic        PRESS_LEVEL   = 1'b0,
   parameter int unsigned LONG_CYCLES   = 50000000,
   parameter int unsigned REPEAT_CYCLES = 10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_held
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
   localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYCLES - 1);

   logic        r_sync1;
   logic        r_sync2;
   logic        r_hist;
   state_t      r_state;
   logic [31:0] r_hold_cnt;
   logic        r_press;
   logic        r_release;
   logic        r_long;
   logic        r_held;

   state_t      w_state_nxt;
   logic [31:0] w_hold_nxt;
   logic        w_press_nxt;
   logic        w_release_nxt;
   logic        w_long_nxt;
   logic        w_press_edge;
   logic        w_release_edge;

`ifdef KEY_EVENT_REPEAT_EN
   logic [31:0] r_rep_cnt;
   logic [31:0] w_rep_nxt;
`else
   // Repeat period is meaningless without the repeat counter.
   logic w_unused_rep;
   assign w_unused_rep = ^REP_LAST;
`endif

   assign w_press_edge   = (r_sync2 == PRESS_LEVEL) && (r_hist != PRESS_LEVEL);
   assign w_release_edge = (r_sync2 != PRESS_LEVEL) && (r_hist == PRESS_LEVEL);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= ~PRESS_LEVEL;
         r_sync2    <= ~PRESS_LEVEL;
         r_hist     <= ~PRESS_LEVEL;
         r_state    <= IDLE;
         r_hold_cnt <= '0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_long     <= 1'b0;
         r_held     <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
         r_rep_cnt  <= '0;
`endif
      end else begin
         r_sync1    <= key_in;
         r_sync2    <= r_sync1;
         r_hist     <= r_sync2;
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_press    <= w_press_nxt;
         r_release  <= w_release_nxt;
         r_long     <= w_long_nxt;
         r_held     <= (w_state_nxt != IDLE);
`ifdef KEY_EVENT_REPEAT_EN
         r_rep_cnt  <= w_rep_nxt;
`endif
      end
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_hold_nxt    = r_hold_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      w_rep_nxt     = r_rep_cnt;
`endif
      case (r_state)
         IDLE: begin
            if (w_press_edge) begin
               w_state_nxt = PRESSED;
               w_hold_nxt  = '0;
               w_press_nxt = 1'b1;
            end
         end
         PRESSED: begin
            // Release outranks the long threshold when both land in the same cycle.
            if (w_release_edge) begin
               w_state_nxt   = IDLE;
               w_release_nxt = 1'b1;
            end else if (r_hold_cnt == LONG_LAST) begin
               w_state_nxt = LONG;
               w_long_nxt  = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
               w_rep_nxt   = '0;
`endif
            end else begin
               w_hold_nxt = r_hold_cnt + 32'd1;
            end
         end
         LONG: begin
            if (w_release_edge) begin
               w_state_nxt   = IDLE;
               w_release_nxt = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
               w_rep_nxt     = '0;
`endif
            end
`ifdef KEY_EVENT_REPEAT_EN
            else if (r_rep_cnt == REP_LAST) begin
               w_press_nxt = 1'b1;
               w_rep_nxt   = '0;
            end else begin
               w_rep_nxt = r_rep_cnt + 32'd1;
            end
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign key_press   = r_press;
   assign key_release = r_release;
   assign key_long    = r_long;
   assign key_held    = r_held;

endmodule

// File: tb/tb_key_event_gen.sv
// Randomized bench for key_event_gen: an active-low and an active-high instance share one stimulus
// and are both compared every cycle against an event-timing model of the key.
module tb_key_event_gen;

   localparam int LONG_C = 8;
   localparam int REP_C  = 4;
`ifdef KEY_EVENT_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic pressed;
   logic key_lo, key_hi;
   logic lo_press, lo_release, lo_long, lo_held;
   logic hi_press, hi_release, hi_long, hi_held;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: sample history of the physical key (index 0 = newest edge)
   bit smp [4];
   bit m_down;
   int m_age;
   logic [3:0] m_exp;

   assign key_lo = ~pressed;
   assign key_hi = pressed;

   key_event_gen #(.PRESS_LEVEL(1'b0), .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(REP_C)) dut_lo (
      .clk(clk), .rst_n(rst_n), .key_in(key_lo),
      .key_press(lo_press), .key_release(lo_release), .key_long(lo_long), .key_held(lo_held)
   );

   key_event_gen #(.PRESS_LEVEL(1'b1), .LONG_CYCLES(LONG_C), .REPEAT_CYCLES(REP_C)) dut_hi (
      .clk(clk), .rst_n(rst_n), .key_in(key_hi),
      .key_press(hi_press), .key_release(hi_release), .key_long(hi_long), .key_held(hi_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got={press,release,long,held}=%b expected=%b", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) smp[i] = 1'b0;
      m_down = 1'b0;
      m_age  = 0;
      m_exp  = 4'b0000;
   endtask

   // A level change sampled at edge n becomes an event visible after edge n+2.
   task automatic model_step(input bit p);
      bit seen, seen_prev;
      for (int i = 3; i > 0; i--) smp[i] = smp[i-1];
      smp[0]    = p;
      seen      = smp[2];
      seen_prev = smp[3];
      m_exp     = 4'b0000;
      if (!m_down && seen && !seen_prev) begin
         m_down   = 1'b1;
         m_age    = 0;
         m_exp[3] = 1'b1;
      end else if (m_down && !seen) begin
         m_down   = 1'b0;
         m_exp[2] = 1'b1;
      end else if (m_down) begin
         m_age++;
         if (m_age == LONG_C) m_exp[1] = 1'b1;
         else if (REP_EN && m_age > LONG_C && ((m_age - LONG_C) % REP_C) == 0) m_exp[3] = 1'b1;
      end
      m_exp[0] = m_down;
   endtask

   // Called at a negedge; drives the key, lets one rising edge pass, checks at the next negedge.
   task automatic step(input bit p, input string tag);
      pressed = p;
      @(posedge clk);
      model_step(p);
      @(negedge clk);
      check({tag, "_lo"}, {lo_press, lo_release, lo_long, lo_held}, m_exp);
      check({tag, "_hi"}, {hi_press, hi_release, hi_long, hi_held}, m_exp);
   endtask

   task automatic run(input bit p, input int n, input string tag);
      for (int i = 0; i < n; i++) step(p, tag);
   endtask

   // Async reset mid-stream: outputs must drop before any clock edge and stay low.
   task automatic pulse_reset(input int cycles, input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, "_rst_lo"}, {lo_press, lo_release, lo_long, lo_held}, 4'b0000);
      check({tag, "_rst_hi"}, {hi_press, hi_release, hi_long, hi_held}, 4'b0000);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check({tag, "_inrst_lo"}, {lo_press, lo_release, lo_long, lo_held}, 4'b0000);
         check({tag, "_inrst_hi"}, {hi_press, hi_release, hi_long, hi_held}, 4'b0000);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      pressed = 1'b0;
      model_reset();
      #1;
      check("por_lo", {lo_press, lo_release, lo_long, lo_held}, 4'b0000);
      check("por_hi", {hi_press, hi_release, hi_long, hi_held}, 4'b0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run(1'b0, 5, "idle");
      run(1'b1, 4, "short");        // press then release 4 cycles later, no long
      run(1'b0, 10, "short_rel");
      run(1'b1, 20, "long");        // long exactly 8 cycles after press
      run(1'b0, 10, "long_rel");
      run(1'b1, 24, "repeat");      // repeat presses only with the macro on
      run(1'b0, 10, "repeat_rel");
      run(1'b1, 7, "thr_m1");
      run(1'b0, 10, "thr_m1_rel");
      run(1'b1, 8, "thr");          // release lands on the threshold cycle
      run(1'b0, 10, "thr_rel");
      run(1'b1, 9, "thr_p1");
      run(1'b0, 10, "thr_p1_rel");
      run(1'b1, 1, "blip");
      run(1'b0, 6, "blip_rel");

      run(1'b1, 15, "pre_rst");     // reach LONG, then reset with key still down
      pulse_reset(3, "mid_long");
      run(1'b1, 12, "post_rst");
      run(1'b0, 8, "post_rst_rel");

      for (int ep = 0; ep < 60; ep++) begin
         run(1'b1, int'($urandom_range(1, 30)), "rnd_down");
         if ($urandom_range(0, 9) == 0) pulse_reset(int'($urandom_range(1, 3)), "rnd");
         run(1'b0, int'($urandom_range(1, 12)), "rnd_up");
      end
      run(1'b0, 6, "drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
